// File: rtl/chip8_fb_pkg.sv
// Shared state encodings, lores geometry and the active-region test for the
// double-buffered CHIP-8/SCHIP framebuffer.
package chip8_fb_pkg;

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR, CLEAR} cpu_state_t;
    typedef enum logic [1:0] {C_IDLE, C_COPY, C_LAST} copy_state_t;

    localparam int unsigned LORES_W = 64;
    localparam int unsigned LORES_H = 32;

    // Hires covers the whole address space, so only lores needs a bound check.
    function automatic logic in_region(input logic [31:0] x, input logic [31:0] y,
                                       input logic hires);
        return hires || ((x < LORES_W) && (y < LORES_H));
    endfunction

endpackage

// File: rtl/chip8_fb_ram.sv
// 1-bit dual-port RAM: port A read/write, port B read-only, both with a
// registered (1-cycle) read.
module chip8_fb_ram #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic          a_wdata,
    output logic          a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic          b_rdata
);

    logic mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/chip8_fb_dbuf.sv
// Double-buffered framebuffer: CPU draws into the back buffer, a copy engine
// moves it to the front buffer, and the VGA side reads the front buffer.
module chip8_fb_dbuf
    import chip8_fb_pkg::*;
#(
    parameter int X_W          = 7,
    parameter int Y_W          = 6,
    parameter int HOLD_CYCLES  = 1024,
    parameter int COPY_TIMEOUT = 833333
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           hires,
    input  logic [X_W-1:0] cpu_x,
    input  logic [Y_W-1:0] cpu_y,
    input  logic           cpu_wdata,
    input  logic           cpu_we,
    input  logic           cpu_xor,
    output logic           cpu_rdata,
    output logic           cpu_collision,
    input  logic           clear_req,
    output logic           busy,
    input  logic [X_W-1:0] vga_x,
    input  logic [Y_W-1:0] vga_y,
    output logic           vga_pixel,
    output logic           copy_active,
    output logic           frame_done
);

    localparam int AW = X_W + Y_W;
    localparam int QW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(COPY_TIMEOUT + 1);
    localparam logic [AW-1:0] ADDR_MAX  = '1;
    localparam logic [QW-1:0] QUIET_MAX = QW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TMO_MAX   = TW'(COPY_TIMEOUT);

    cpu_state_t  cpu_state_reg, cpu_state_next;
    copy_state_t copy_state_reg, copy_state_next;

    logic [AW-1:0] rmw_addr_reg, clr_addr_reg, rd_addr_reg, wr_addr_reg;
    logic          rmw_data_reg, hires_reg, collision_reg, dirty_reg;
    logic          wr_en_reg, frame_done_reg, cpu_region_reg, vga_region_reg;
    logic [QW-1:0] quiet_reg;
    logic [TW-1:0] tmo_reg;

    logic [AW-1:0] cpu_addr, back_addr;
    logic          back_we, back_wdata, back_a_rdata, back_b_rdata;
    logic          front_b_rdata, front_rdata_unused;
    logic          cpu_in_region, clear_start, write_start, clear_done;
    logic          copy_start, behind, dirty_set;

    assign cpu_addr      = {cpu_y, cpu_x};
    assign cpu_in_region = in_region(32'(cpu_x), 32'(cpu_y), hires);
    // A mode change is only noticed from IDLE, so it is never lost while busy.
    assign clear_start   = (cpu_state_reg == IDLE) && (clear_req || (hires != hires_reg));
    assign write_start   = (cpu_state_reg == IDLE) && !clear_start && cpu_we && cpu_in_region;
    assign clear_done    = (cpu_state_reg == CLEAR) && (clr_addr_reg == ADDR_MAX);

    always_comb begin
        cpu_state_next = cpu_state_reg;
        back_addr      = cpu_addr;
        back_we        = 1'b0;
        back_wdata     = cpu_wdata;
        case (cpu_state_reg)
            IDLE: begin
                if (clear_start) begin
                    cpu_state_next = CLEAR;
                end else if (write_start) begin
                    if (cpu_xor) cpu_state_next = RMW_RD;
                    else         back_we = 1'b1;
                end
            end
            RMW_RD: begin
                back_addr      = rmw_addr_reg;
                cpu_state_next = RMW_WR;
            end
            RMW_WR: begin
                back_addr      = rmw_addr_reg;
                back_we        = 1'b1;
                back_wdata     = back_a_rdata ^ rmw_data_reg;
                cpu_state_next = IDLE;
            end
            CLEAR: begin
                back_addr  = clr_addr_reg;
                back_we    = 1'b1;
                back_wdata = 1'b0;
                if (clear_done) cpu_state_next = IDLE;
            end
            default: cpu_state_next = IDLE;
        endcase
    end

    assign copy_start = (copy_state_reg == C_IDLE) &&
                        ((dirty_reg && (quiet_reg == QUIET_MAX)) || (tmo_reg == TMO_MAX));
    // Writes ahead of the copy read pointer are picked up by the running copy.
    assign behind     = !((copy_state_reg == C_COPY) && (back_addr > rd_addr_reg));
    assign dirty_set  = (back_we && (cpu_state_reg != CLEAR) && behind) || clear_done;

    always_comb begin
        copy_state_next = copy_state_reg;
        case (copy_state_reg)
            C_IDLE:  if (copy_start) copy_state_next = C_COPY;
            C_COPY:  if (rd_addr_reg == ADDR_MAX) copy_state_next = C_LAST;
            C_LAST:  copy_state_next = C_IDLE;
            default: copy_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_state_reg  <= IDLE;
            rmw_addr_reg   <= '0;
            rmw_data_reg   <= 1'b0;
            clr_addr_reg   <= '0;
            hires_reg      <= 1'b0;
            collision_reg  <= 1'b0;
            cpu_region_reg <= 1'b0;
            vga_region_reg <= 1'b0;
        end else begin
            cpu_state_reg <= cpu_state_next;
            if (write_start && cpu_xor) begin
                rmw_addr_reg <= cpu_addr;
                rmw_data_reg <= cpu_wdata;
            end
            if ((cpu_state_reg == CLEAR) && !clear_done) clr_addr_reg <= clr_addr_reg + AW'(1);
            else                                         clr_addr_reg <= '0;
            if (clear_start) begin
                hires_reg     <= hires;
                collision_reg <= 1'b0;
            end else if ((cpu_state_reg == RMW_WR) && back_a_rdata && rmw_data_reg) begin
                collision_reg <= 1'b1;
            end
            cpu_region_reg <= (cpu_state_reg == IDLE) && cpu_in_region;
            vga_region_reg <= in_region(32'(vga_x), 32'(vga_y), hires);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            copy_state_reg <= C_IDLE;
            quiet_reg      <= '0;
            tmo_reg        <= '0;
            dirty_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            wr_addr_reg    <= '0;
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            copy_state_reg <= copy_state_next;
            if (back_we)                     quiet_reg <= '0;
            else if (quiet_reg != QUIET_MAX) quiet_reg <= quiet_reg + QW'(1);
            // The start cycle counts as the first cycle of the next timeout period.
            if (copy_start)              tmo_reg <= TW'(1);
            else if (tmo_reg != TMO_MAX) tmo_reg <= tmo_reg + TW'(1);
            dirty_reg <= dirty_set || (dirty_reg && !copy_start);
            if (copy_state_reg == C_IDLE)                                   rd_addr_reg <= '0;
            else if ((copy_state_reg == C_COPY) && (rd_addr_reg != ADDR_MAX)) rd_addr_reg <= rd_addr_reg + AW'(1);
            wr_addr_reg    <= rd_addr_reg;
            wr_en_reg      <= (copy_state_reg == C_COPY);
            frame_done_reg <= (copy_state_reg == C_LAST);
        end
    end

    chip8_fb_ram #(.AW(AW)) u_back (
        .clk     (clk),
        .a_addr  (back_addr),
        .a_we    (back_we),
        .a_wdata (back_wdata),
        .a_rdata (back_a_rdata),
        .b_addr  (rd_addr_reg),
        .b_rdata (back_b_rdata)
    );

    chip8_fb_ram #(.AW(AW)) u_front (
        .clk     (clk),
        .a_addr  (wr_addr_reg),
        .a_we    (wr_en_reg),
        .a_wdata (back_b_rdata),
        .a_rdata (front_rdata_unused),
        .b_addr  ({vga_y, vga_x}),
        .b_rdata (front_b_rdata)
    );

    assign busy          = (cpu_state_reg != IDLE);
    assign copy_active   = (copy_state_reg != C_IDLE);
    assign frame_done    = frame_done_reg;
    assign cpu_collision = collision_reg;
    assign cpu_rdata     = back_a_rdata & cpu_region_reg;
    assign vga_pixel     = front_b_rdata & vga_region_reg;

endmodule

// File: tb/tb_chip8_fb_dbuf.sv
// Directed bench for chip8_fb_dbuf: clear, plain/XOR draw, copy timing,
// forced copy, mode-change clear, dropped writes and reset mid-copy.
module tb_chip8_fb_dbuf;

    localparam int X_W   = 7;
    localparam int Y_W   = 6;
    localparam int HOLD  = 16;
    localparam int TMO   = 20000;
    localparam int DEPTH = 8192;

    logic           clk = 1'b0;
    logic           reset_n, hires, cpu_wdata, cpu_we, cpu_xor, clear_req;
    logic [X_W-1:0] cpu_x, vga_x;
    logic [Y_W-1:0] cpu_y, vga_y;
    logic           cpu_rdata, cpu_collision, busy, vga_pixel, copy_active, frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    chip8_fb_dbuf #(
        .X_W(X_W), .Y_W(Y_W), .HOLD_CYCLES(HOLD), .COPY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hires(hires),
        .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_xor(cpu_xor), .cpu_rdata(cpu_rdata), .cpu_collision(cpu_collision),
        .clear_req(clear_req), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_pixel(vga_pixel), .copy_active(copy_active), .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-24s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    endtask

    task automatic plain_wr(input int x, input int y, input logic d);
        cpu_x = 7'(x); cpu_y = 6'(y); cpu_wdata = d; cpu_xor = 1'b0; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic xor_wr(input int x, input int y, input logic d);
        cpu_x = 7'(x); cpu_y = 6'(y); cpu_wdata = d; cpu_xor = 1'b1; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_xor = 1'b0;
        check("xor_busy_c1", busy, 1);
        tick();
        check("xor_busy_c2", busy, 1);
        tick();
        check("xor_busy_end", busy, 0);
    endtask

    task automatic cpu_rd(input int x, input int y, input logic e, input string tag);
        cpu_x = 7'(x); cpu_y = 6'(y);
        tick();
        check(tag, cpu_rdata, e);
    endtask

    task automatic vga_rd(input int x, input int y, input logic e, input string tag);
        vga_x = 7'(x); vga_y = 6'(y);
        tick();
        check(tag, vga_pixel, e);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy && n < DEPTH + 100) begin
            n++;
            tick();
        end
        check(tag, n, DEPTH);
    endtask

    task automatic wait_copy(input int limit, output int n);
        n = 0;
        while (!copy_active && n < limit) begin
            tick();
            n++;
        end
        check("copy_started", copy_active, 1);
    endtask

    task automatic copy_run(input string tag);
        int n = 0;
        while (copy_active && n < DEPTH + 100) begin
            n++;
            tick();
        end
        check(tag, n, DEPTH + 1);
        check("frame_done_pulse", frame_done, 1);
        tick();
        check("frame_done_low", frame_done, 0);
    endtask

    initial begin
        int n, s1, any;
        reset_n = 1'b0; hires = 1'b0; cpu_wdata = 1'b0; cpu_we = 1'b0; cpu_xor = 1'b0;
        clear_req = 1'b0; cpu_x = '0; cpu_y = '0; vga_x = '0; vga_y = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_copy_active", copy_active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_collision", cpu_collision, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vga_pixel", vga_pixel, 0);
        reset_n = 1'b1;
        tick();

        // Clear, single write, quiet-triggered copy
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        count_busy("clear_busy_len");
        plain_wr(3, 2, 1'b1);
        wait_copy(HOLD + 100, n);
        check("quiet_copy_delay", n, HOLD + 1);
        s1 = cyc;
        copy_run("copy1_len");
        vga_rd(3, 2, 1'b1, "vga_3_2");
        vga_rd(4, 2, 1'b0, "vga_4_2");

        // Forced copy with no CPU activity
        wait_copy(TMO + 100, n);
        check("forced_copy_interval", cyc - s1, TMO);
        copy_run("copy_forced_len");

        // XOR draw and collision
        xor_wr(10, 5, 1'b1);
        check("xor1_collision", cpu_collision, 0);
        cpu_rd(10, 5, 1'b1, "xor1_pixel");
        xor_wr(10, 5, 1'b1);
        check("xor2_collision", cpu_collision, 1);
        cpu_rd(10, 5, 1'b0, "xor2_pixel");
        wait_copy(HOLD + 100, n);
        copy_run("copy_xor_len");

        // Out-of-region lores write is ignored
        plain_wr(100, 40, 1'b1);
        any = 0;
        repeat (HOLD + 10) begin
            tick();
            if (copy_active) any = 1;
        end
        check("oor_no_copy", any, 0);
        cpu_rd(100, 40, 1'b0, "oor_cpu_rdata");
        vga_rd(100, 40, 1'b0, "oor_vga_pixel");

        // Mode change triggers a clear that also drops the collision flag
        hires = 1'b1;
        tick();
        check("hires_clear_busy", busy, 1);
        check("hires_clear_collision", cpu_collision, 0);
        count_busy("hires_clear_len");
        plain_wr(100, 40, 1'b1);
        wait_copy(HOLD + 100, n);
        check("hires_copy_delay", n, HOLD + 1);
        copy_run("copy_hires_len");
        vga_rd(100, 40, 1'b1, "hires_vga_100_40");
        cpu_rd(100, 40, 1'b1, "hires_cpu_100_40");

        // Plain writes during an XOR are dropped
        cpu_x = 7'd20; cpu_y = 6'd7; cpu_wdata = 1'b1; cpu_xor = 1'b1; cpu_we = 1'b1;
        tick();
        cpu_xor = 1'b0; cpu_wdata = 1'b0;
        check("drop_busy_c1", busy, 1);
        tick();
        check("drop_busy_c2", busy, 1);
        tick();
        cpu_we = 1'b0;
        check("drop_busy_end", busy, 0);
        cpu_rd(20, 7, 1'b1, "dropped_write_pixel");

        // Clear wins over a simultaneous write
        cpu_x = 7'd21; cpu_y = 6'd7; cpu_wdata = 1'b1; cpu_we = 1'b1; clear_req = 1'b1;
        tick();
        cpu_we = 1'b0; clear_req = 1'b0;
        check("clear_wins_busy", busy, 1);
        count_busy("clear_wins_len");
        cpu_rd(21, 7, 1'b0, "clear_wins_pixel");
        cpu_rd(20, 7, 1'b0, "cleared_xor_pixel");

        // Reset in the middle of a copy
        wait_copy(HOLD + 100, n);
        repeat (300) tick();
        reset_n = 1'b0;
        hires = 1'b0;
        #1;
        check("rst_mid_copy_active", copy_active, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame_done", frame_done, 0);
        tick();
        tick();
        check("rst_mid_cpu_rdata", cpu_rdata, 0);
        check("rst_mid_vga_pixel", vga_pixel, 0);
        reset_n = 1'b1;
        any = 0;
        repeat (20) begin
            tick();
            if (frame_done || copy_active || busy) any = 1;
        end
        check("post_rst_quiet", any, 0);
        plain_wr(3, 2, 1'b1);
        wait_copy(HOLD + 100, n);
        check("post_rst_copy_delay", n, HOLD + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
